// File: rtl/avl_slave_mem.sv
// Avalon-MM responder backed by a word-organised scratch memory.
//
// Each transfer stalls the master for a programmable number of wait states, then
// acknowledges it for exactly one cycle (the ACK cycle, waitrequest low). Reads return
// registered data in the ACK cycle. Writes are byte-masked and commit on the edge
// leaving ACK.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset_n      asynchronous active-low reset (FSM, wait counter, readdata)
//   address      byte address; word index = address[DEPTH_LOG2+1:2], other bits ignored
//   read         read request, held by the master until waitrequest is low
//   write        write request, held by the master until waitrequest is low
//   writedata    lane-aligned write data
//   byteenable   per-lane write enables (ignored for reads)
//   readdata     registered read data, valid in the ACK cycle, held until the next read
//   waitrequest  stall to the master; low only in the ACK cycle or when idle
module avl_slave_mem #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata,
  input  logic [3:0]            byteenable,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  waitrequest
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  // Counter value of the last wait cycle; unused when WAIT_STATES is 0.
  localparam logic [3:0] WaitLast = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [DEPTH_LOG2-1:0] index;
  logic                  req;
  logic                  load_rd;
  logic                  commit_wr;

  assign req   = read | write;
  assign index = address[DEPTH_LOG2+1:2];

  // Byte offset and bits above the index are deliberately ignored (addresses wrap).
  logic unused_addr;
  assign unused_addr = ^{address[ADDR_WIDTH-1:DEPTH_LOG2+2], address[1:0]};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d   = 4'd0;
          state_d = (WAIT_STATES == 0) ? StAck : StWait;
        end
      end
      StWait: begin
        if (!req) begin
          // Master withdrew the request: abandon without side effects.
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q == WaitLast) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StAck: begin
        // Always one IDLE cycle after ACK, even with a request pending.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    waitrequest = req & (state_q != StAck);
    // read+write together is treated as a write, so readdata must not load.
    load_rd     = (state_d == StAck) & read & ~write;
    commit_wr   = (state_q == StAck) & write;
  end

  // Read data is captured on the edge entering ACK and held until the next read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (load_rd) begin
      readdata <= mem[index];
    end
  end

  // Memory contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          mem[index][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

endmodule
